// File: rtl/ws2812_frame_ctrl.sv
// Frame-buffer controller for the WS2812 sender: two-requester write arbiter, shadow buffer,
// and a commit that swaps into the active buffer only inside the reset gap. Macro: WS2812_CTRL_BRIGHT_EN.
module ws2812_frame_ctrl #(
    parameter int unsigned DEPTH  = 24,
    parameter int unsigned WS_NUM = 7,
    parameter int unsigned CLKHZ  = 50_000_000,
    parameter int unsigned GAP_US = 100,
    parameter int unsigned RES_US = 500,
    localparam int unsigned ADDR_W = $clog2(WS_NUM)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [1:0]                       wr_valid,
    output logic [1:0]                       wr_ready,
    input  logic [2*ADDR_W-1:0]              wr_addr,
    input  logic [2*DEPTH-1:0]               wr_data,
    input  logic [1:0]                       commit_req,
    input  logic                             data_stream,
`ifdef WS2812_CTRL_BRIGHT_EN
    input  logic [7:0]                       bright,
`endif
    output logic [WS_NUM-1:0][DEPTH-1:0]     wscolor,
    output logic                             commit_done,
    output logic                             busy,
    output logic                             err_addr
);

    localparam int unsigned GAP_CYC = 32'((64'(GAP_US) * 64'(CLKHZ)) / 64'd1_000_000);
    localparam int unsigned RES_CYC = 32'((64'(RES_US) * 64'(CLKHZ)) / 64'd1_000_000);
    localparam int unsigned WIN_HI  = RES_CYC - 8;
    localparam int unsigned CNT_W   = $clog2(RES_CYC + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_GAP = 2'd1,
        SWAP     = 2'd2
    } state_t;

    state_t                          state_q, state_d;
    logic [WS_NUM-1:0][DEPTH-1:0]    shadow_q;
    logic [WS_NUM-1:0][DEPTH-1:0]    active_q;
    logic [CNT_W-1:0]                cnt_q;
    logic                            gap_used_q;
    logic                            last_grant_q;
    logic                            commit_done_q;
    logic                            busy_q;
    logic                            err_addr_q;

    logic                            accept;
    logic                            sel;
    logic [ADDR_W-1:0]               sel_addr;
    logic [DEPTH-1:0]                sel_data;
    logic                            addr_ok;
    logic                            in_window;
    logic                            swap_go;

    // Round-robin grant; the requester not served last time wins a contention.
    always_comb begin
        wr_ready = 2'b00;
        if (state_q != SWAP) begin
            if (wr_valid == 2'b11) begin
                wr_ready = last_grant_q ? 2'b01 : 2'b10;
            end else begin
                wr_ready = wr_valid;
            end
        end
    end

    assign accept   = |(wr_valid & wr_ready);
    assign sel      = wr_ready[1];
    assign sel_addr = sel ? wr_addr[2*ADDR_W-1:ADDR_W] : wr_addr[ADDR_W-1:0];
    assign sel_data = sel ? wr_data[2*DEPTH-1:DEPTH] : wr_data[DEPTH-1:0];
    assign addr_ok  = 32'(sel_addr) < WS_NUM;

    // One swap per gap: gap_used blocks a re-pended commit until the line goes high again.
    assign in_window = (cnt_q >= CNT_W'(GAP_CYC)) && (cnt_q <= CNT_W'(WIN_HI)) && !gap_used_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        swap_go = 1'b0;
        case (state_q)
            IDLE: begin
                if (|commit_req) begin
                    state_d = WAIT_GAP;
                end
            end
            WAIT_GAP: begin
                if (in_window && !accept) begin
                    state_d = SWAP;
                    swap_go = 1'b1;
                end
            end
            SWAP: begin
                state_d = (|commit_req) ? WAIT_GAP : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Low-time counter on the sender output, saturating at the reset-gap length.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            gap_used_q <= 1'b0;
        end else begin
            if (data_stream) begin
                cnt_q <= '0;
            end else if (cnt_q < CNT_W'(RES_CYC)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (data_stream) begin
                gap_used_q <= 1'b0;
            end else if (swap_go) begin
                gap_used_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q      <= '0;
            active_q      <= '0;
            last_grant_q  <= 1'b1;
            commit_done_q <= 1'b0;
            busy_q        <= 1'b0;
            err_addr_q    <= 1'b0;
        end else begin
            if (accept) begin
                last_grant_q <= sel;
                if (addr_ok) begin
                    shadow_q[sel_addr] <= sel_data;
                end
            end
            if (swap_go) begin
                active_q <= shadow_q;
            end
            commit_done_q <= swap_go;
            busy_q        <= (state_d != IDLE);
            err_addr_q    <= accept && !addr_ok;
        end
    end

    assign commit_done = commit_done_q;
    assign busy        = busy_q;
    assign err_addr    = err_addr_q;

`ifdef WS2812_CTRL_BRIGHT_EN
    logic [WS_NUM-1:0][DEPTH-1:0] scaled_q;

    function automatic logic [7:0] scale_ch(input logic [7:0] ch, input logic [7:0] b);
        logic [15:0] prod;
        prod = 16'(ch) * (16'(b) + 16'd1);
        return 8'(prod >> 8);
    endfunction

    // Per-channel brightness scaling, registered; bright=255 passes colours through.
    always_ff @(posedge clk) begin
        if (rst) begin
            scaled_q <= '0;
        end else begin
            for (int l = 0; l < int'(WS_NUM); l++) begin
                for (int c = 0; c < int'(DEPTH / 8); c++) begin
                    scaled_q[l][c*8 +: 8] <= scale_ch(active_q[l][c*8 +: 8], bright);
                end
            end
        end
    end

    assign wscolor = scaled_q;
`else
    assign wscolor = active_q;
`endif

endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// Directed bench for ws2812_frame_ctrl with a commit-frame scoreboard.
// Define WS2812_CTRL_BRIGHT_EN at compile time to cover brightness scaling.
`timescale 1ns/1ps
module tb_ws2812_frame_ctrl;
    localparam int unsigned DEPTH  = 24;
    localparam int unsigned WS_NUM = 7;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned FW     = WS_NUM * DEPTH;

    logic                         clk = 1'b0;
    logic                         rst;
    logic [1:0]                   wr_valid;
    logic [1:0]                   wr_ready;
    logic [2*ADDR_W-1:0]          wr_addr;
    logic [2*DEPTH-1:0]           wr_data;
    logic [1:0]                   commit_req;
    logic                         data_stream;
    logic [WS_NUM-1:0][DEPTH-1:0] wscolor;
    logic                         commit_done;
    logic                         busy;
    logic                         err_addr;
`ifdef WS2812_CTRL_BRIGHT_EN
    logic [7:0]                   bright;
`endif

    int errs   = 0;
    int checks = 0;

    logic [WS_NUM-1:0][DEPTH-1:0] sh_m;
    logic [WS_NUM-1:0][DEPTH-1:0] act_m;
    logic [FW-1:0]                frame_q[$];
    logic [1:0]                   grant_q[$];

    always #5 clk = ~clk;

    ws2812_frame_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .commit_req  (commit_req),
        .data_stream (data_stream),
`ifdef WS2812_CTRL_BRIGHT_EN
        .bright      (bright),
`endif
        .wscolor     (wscolor),
        .commit_done (commit_done),
        .busy        (busy),
        .err_addr    (err_addr)
    );

    task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [FW-1:0] out_of(input logic [FW-1:0] f);
        logic [FW-1:0] r;
        r = f;
`ifdef WS2812_CTRL_BRIGHT_EN
        for (int i = 0; i < int'(FW / 8); i++) begin
            logic [15:0] p;
            p = 16'(f[i*8 +: 8]) * (16'(bright) + 16'd1);
            r[i*8 +: 8] = p[15:8];
        end
`endif
        return r;
    endfunction

    // Default build: wscolor must already show the new frame in the swap cycle.
    task automatic frame_now(input string tag, input logic [FW-1:0] exp);
`ifndef WS2812_CTRL_BRIGHT_EN
        check(tag, wscolor, exp);
`endif
    endtask

    // Brightness build: scaled output appears one cycle after the swap.
    task automatic frame_late(input string tag, input logic [FW-1:0] exp);
`ifdef WS2812_CTRL_BRIGHT_EN
        check(tag, wscolor, out_of(exp));
`endif
    endtask

    task automatic wait_done(input int max, input logic [FW-1:0] hold, output int lat, output bit stable);
        lat    = -1;
        stable = 1'b1;
        for (int n = 1; n <= max; n++) begin
            tick();
            if (commit_done === 1'b1) begin
                lat = n;
                break;
            end
            if (wscolor !== out_of(hold)) stable = 1'b0;
        end
    endtask

    task automatic count_done(input int cycles, output int cnt);
        cnt = 0;
        for (int n = 0; n < cycles; n++) begin
            tick();
            if (commit_done === 1'b1) cnt++;
        end
    endtask

    task automatic set_write(input int r, input logic [ADDR_W-1:0] a, input logic [DEPTH-1:0] d);
        wr_valid[r]               = 1'b1;
        wr_addr[r*ADDR_W +: ADDR_W] = a;
        wr_data[r*DEPTH +: DEPTH]   = d;
    endtask

    task automatic new_gap();
        data_stream = 1'b1;
        repeat (3) tick();
        data_stream = 1'b0;
    endtask

    // Waits for the swap after a gap starts, then checks latency, stability and the popped frame.
    task automatic expect_swap(input string tag, input int lo, input int hi);
        int            lat;
        bit            stable;
        logic [FW-1:0] exp_f;
        wait_done(6000, act_m, lat, stable);
        check($sformatf("%s_latency_%0d", tag, lat), FW'(lat >= lo && lat <= hi), FW'(1));
        check({tag, "_stable_before"}, FW'(stable), FW'(1));
        check({tag, "_busy_in_swap"}, FW'(busy), FW'(1));
        exp_f = (frame_q.size() != 0) ? frame_q.pop_front() : '0;
        act_m = exp_f;
        frame_now({tag, "_frame"}, exp_f);
    endtask

    initial begin
        logic       lg;
        logic [1:0] eg;
        int         nd;

        rst         = 1'b1;
        wr_valid    = '0;
        wr_addr     = '0;
        wr_data     = '0;
        commit_req  = '0;
        data_stream = 1'b1;
`ifdef WS2812_CTRL_BRIGHT_EN
        bright      = 8'd255;
`endif
        sh_m  = '0;
        act_m = '0;
        lg    = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        check("reset_wscolor", wscolor, '0);
        check("reset_commit_done", FW'(commit_done), '0);
        check("reset_busy", FW'(busy), '0);
        check("reset_err_addr", FW'(err_addr), '0);

        // Both requesters contend every cycle: grants must alternate starting with 0.
        set_write(0, 3'd0, 24'hFF0000);
        set_write(1, 3'd1, 24'h00FF00);
        for (int i = 0; i < 4; i++) begin
            eg = lg ? 2'b01 : 2'b10;
            lg = ~lg;
            grant_q.push_back(eg);
            #1;
            check($sformatf("grant_alt_%0d", i), FW'(wr_ready), FW'(grant_q.pop_front()));
            tick();
        end
        sh_m[0] = 24'hFF0000;
        sh_m[1] = 24'h00FF00;

        wr_valid = 2'b10;
        #1;
        check("grant_single_1", FW'(wr_ready), FW'(2'b10));
        tick();
        lg = 1'b1;
        wr_valid = 2'b11;
        #1;
        check("grant_after_single", FW'(wr_ready), FW'(2'b01));
        tick();
        lg = 1'b0;
        wr_valid = 2'b00;

        // Fill all LEDs from requester 0, then commit and open a gap.
        for (int i = 0; i < int'(WS_NUM); i++) begin
            set_write(0, 3'(i), {8'(i * 16 + 1), 8'(255 - i), 8'(i * 37)});
            sh_m[i] = {8'(i * 16 + 1), 8'(255 - i), 8'(i * 37)};
            #1;
            check($sformatf("grant_fill_%0d", i), FW'(wr_ready), FW'(2'b01));
            tick();
        end
        wr_valid   = 2'b00;
        commit_req = 2'b01;
        frame_q.push_back(sh_m);
        tick();
        commit_req = 2'b00;
        check("busy_pending", FW'(busy), FW'(1));
        data_stream = 1'b0;
        expect_swap("swap1", 4999, 5002);
        tick();
        frame_late("swap1_frame_late", act_m);
        check("swap1_done_pulse", FW'(commit_done), '0);
        check("swap1_busy_idle", FW'(busy), '0);

        // Missed window: commit arrives when the low count is 24995.
        set_write(1, 3'd3, 24'hABCDEF);
        sh_m[3] = 24'hABCDEF;
        tick();
        wr_valid = 2'b00;
        data_stream = 1'b1;
        repeat (3) tick();
        data_stream = 1'b0;
        repeat (24995) tick();
        commit_req = 2'b01;
        frame_q.push_back(sh_m);
        tick();
        commit_req = 2'b00;
        count_done(40, nd);
        check("missed_no_swap", FW'(nd), '0);
        check("missed_busy", FW'(busy), FW'(1));
        new_gap();
        expect_swap("swap2", 4999, 5002);
        tick();
        frame_late("swap2_frame_late", act_m);

        // Out-of-range address is accepted, flagged once, and leaves the shadow unchanged.
        set_write(1, 3'd7, 24'h123456);
        #1;
        check("oor_ready", FW'(wr_ready), FW'(2'b10));
        tick();
        wr_valid = 2'b00;
        check("oor_err_pulse", FW'(err_addr), FW'(1));
        tick();
        check("oor_err_clear", FW'(err_addr), '0);

        // Merging: simultaneous commits plus one during WAIT_GAP give a single swap.
        data_stream = 1'b1;
        commit_req  = 2'b11;
        frame_q.push_back(sh_m);
        tick();
        commit_req = 2'b00;
        repeat (3) tick();
        commit_req = 2'b01;
        tick();
        commit_req  = 2'b00;
        data_stream = 1'b0;
        expect_swap("swap3", 4999, 5002);
        set_write(0, 3'd2, 24'h555555);
        commit_req = 2'b10;
        #1;
        check("ready_blocked_in_swap", FW'(wr_ready), '0);
        frame_q.push_back(sh_m);
        tick();
        wr_valid   = 2'b00;
        commit_req = 2'b00;
        frame_late("swap3_frame_late", act_m);
        check("repend_busy", FW'(busy), FW'(1));
        count_done(200, nd);
        check("one_swap_per_gap", FW'(nd), '0);
        new_gap();
        expect_swap("swap4", 4999, 5002);
        tick();
        frame_late("swap4_frame_late", act_m);
        check("swap4_busy_idle", FW'(busy), '0);

        // Reset with a commit pending discards it and clears both buffers.
        data_stream = 1'b1;
        commit_req  = 2'b01;
        tick();
        commit_req  = 2'b00;
        data_stream = 1'b0;
        repeat (100) tick();
        rst = 1'b1;
        tick();
        rst   = 1'b0;
        sh_m  = '0;
        act_m = '0;
        check("midrst_busy", FW'(busy), '0);
        check("midrst_wscolor", wscolor, '0);
        count_done(5100, nd);
        check("midrst_no_swap", FW'(nd), '0);
        commit_req = 2'b01;
        frame_q.push_back(sh_m);
        tick();
        commit_req = 2'b00;
        expect_swap("swap5", 1, 3);
        tick();
        frame_late("swap5_frame_late", act_m);

`ifdef WS2812_CTRL_BRIGHT_EN
        // Brightness 127 scales 0xFF8000 to 0x7F4000 one cycle after the swap.
        bright = 8'd127;
        set_write(0, 3'd0, 24'hFF8000);
        sh_m[0] = 24'hFF8000;
        tick();
        wr_valid   = 2'b00;
        commit_req = 2'b01;
        frame_q.push_back(sh_m);
        tick();
        commit_req = 2'b00;
        new_gap();
        expect_swap("swap6", 4999, 5002);
        tick();
        check("bright_127", FW'(wscolor[0]), FW'(24'h7F4000));
        bright = 8'd255;
        tick();
        check("bright_255", FW'(wscolor[0]), FW'(24'hFF8000));
`endif

        check("scoreboard_empty", FW'(frame_q.size()), '0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/ws2812_frame_ctrl.md
Name: ws2812_frame_ctrl

Overview:
- Frame-buffer controller and write arbiter that sits in front of the WS2812 serial sender.
- Two requesters (host bus, local pattern engine) share one shadow colour buffer through a round-robin arbiter.
- On commit, the shadow buffer is copied atomically into the active buffer that drives the sender's parallel `wscolor` array.
- The copy happens only inside the sender's reset gap, detected from `data_stream`, so a frame is never torn.

Parameters:
- DEPTH, 24, bits per LED colour (RGB888, R in [23:16]).
- WS_NUM, 7, number of LEDs in the chain.
- CLKHZ, 50_000_000, clock frequency in Hz.
- GAP_US, 100, minimum continuous low time on `data_stream` that qualifies as the reset gap.
- RES_US, 500, sender reset-gap length; bounds the swap window.
- ADDR_W, $clog2(WS_NUM), LED address width (localparam).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- wr_valid  in  2  per-requester write request
- wr_ready  out  2  per-requester grant; combinational
- wr_addr  in  2xADDR_W  LED index, packed, requester 0 in the low slice
- wr_data  in  2xDEPTH  RGB colour, packed, requester 0 in the low slice
- commit_req  in  2  per-requester single-cycle commit pulse
- data_stream  in  1  sender output, monitored for the reset gap
- wscolor  out  [WS_NUM] x DEPTH  active colours to the sender
- commit_done  out  1  single-cycle pulse on the swap cycle
- busy  out  1  commit pending or swap in progress
- err_addr  out  1  single-cycle pulse on an accepted out-of-range write

Behaviour:
- Reset: shadow and active buffers cleared to 0; `wscolor`=0; `commit_done`=0; `err_addr`=0; `busy`=0; state IDLE; gap counter 0; last_grant=1, so requester 0 wins the first contention.
- Arbitration:
  - At most one write per cycle.
  - With a single valid request, that requester is granted.
  - With both valid, the requester not granted last time wins.
  - last_grant updates only on an accepted write (valid & ready).
  - `wr_ready` is forced to 0 during SWAP.
- Write:
  - On accept, `shadow[addr] <= data` at the next edge.
  - If addr >= WS_NUM, the write is accepted but discarded, and `err_addr` pulses the next cycle.
- Gap counter:
  - Increments while `data_stream`=0 and resets to 0 when `data_stream`=1.
  - Saturates at RES_CYC.
  - GAP_CYC = GAP_US*CLKHZ/1e6; RES_CYC = RES_US*CLKHZ/1e6.
  - Swap window: GAP_CYC <= count <= RES_CYC-8. The upper bound keeps the swap clear of the sender's wscolor[0] fetch at the end of its reset gap.
- FSM:
  - IDLE: any `commit_req` -> WAIT_GAP.
  - WAIT_GAP:
    - In window with no write accepted this cycle -> SWAP.
    - A write in the same cycle defers the swap by one cycle.
    - If the window is missed (count exceeds RES_CYC-8), wait for the next gap.
  - SWAP: lasts exactly one cycle; `active <= shadow` (all entries at one edge); `commit_done`=1.
    - A `commit_req` seen in SWAP sets a re-pending flag -> WAIT_GAP.
    - Otherwise -> IDLE.
- Commit merging: commits arriving while already in WAIT_GAP merge into the single pending swap. Simultaneous `commit_req` from both requesters produces one commit.
- `busy` = (state != IDLE).
- Mid-operation reset: rst wins over every event; pending commits are discarded and both buffers are cleared.
- `wscolor` is driven combinationally from the active registers, so it changes only on a SWAP edge.

Optional Feature:
- Macro: WS2812_CTRL_BRIGHT_EN.
- Defined:
  - Adds input `bright` [7:0].
  - Each 8-bit channel of `wscolor` = (active_ch*(bright+1))>>8.
  - The scaled values are registered, so `wscolor` lags the SWAP edge and any `bright` change by 1 cycle.
  - Reset value 0.
  - bright=255 gives pass-through.
- Undefined: no `bright` port; `wscolor` = active buffer with no added latency.

Test Plan:
- Write arbitration: both requesters valid every cycle after reset (req0 addr0=0xFF0000, req1 addr1=0x00FF00) -> grants alternate 0,1,0,1; first grant is requester 0.
- Commit swap timing: writes to LEDs 0..6, commit_req, `data_stream` low from cycle T -> `commit_done` at cycle T+5000 ±1, `wscolor` updated at that edge, unchanged before it.
- Missed window: commit issued while the low count is already 24995 -> no swap; `data_stream` pulses high, then low -> swap when the count reaches 5000 in the new gap.
- Out-of-range address: write to addr 7 with WS_NUM=7 -> `err_addr` pulses once, all shadow entries unchanged after commit.
- Commit merging: commits from both requesters in the same cycle, then another during WAIT_GAP -> exactly one `commit_done`. A commit during SWAP -> a second `commit_done` in the next gap.
- Brightness (macro defined): bright=127, active 0xFF8000 -> `wscolor`=0x7F4000 one cycle after swap.
